// File: rtl/co_seq_ctrl.sv
// co_seq_ctrl: frame-level sequencer for the carrier-offset derotator.
// Latches an FCW into a shadow register, loads it into the NCO at frame start,
// waits for the NCO to settle, gates the derotator for frame_len samples and
// aligns valid/SOF/EOF with the derotator's DP_LAT-cycle output latency.
// Build option: define CO_PHASE_CONT_EN to pulse nco_clr only on the first
// LOAD after rst, keeping NCO phase continuous across later frames.
module co_seq_ctrl #(
  parameter int FCW_W   = 16,
  parameter int LEN_W   = 12,
  parameter int DP_LAT  = 2,
  parameter int NCO_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FCW_W-1:0] cfg_fcw,
  input  logic             cfg_load,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  output logic [FCW_W-1:0] nco_fcw,
  output logic             nco_load,
  output logic             nco_clr,
  output logic             rot_en,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic             frame_done,
  output logic             err_drop,
  output logic             err_start
);

  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] WARM_INIT  = TMR_W'(NCO_LAT - 1);
  localparam logic [TMR_W-1:0] DRAIN_INIT = TMR_W'(DP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [FCW_W-1:0]   shadow_q, shadow_d;
  logic [FCW_W-1:0]   nco_fcw_q, nco_fcw_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               nco_load_q, nco_load_d;
  logic               nco_clr_q, nco_clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_drop_q, err_drop_d;
  logic               err_start_q, err_start_d;
  logic [DP_LAT-1:0]  vld_q, vld_d;
  logic [DP_LAT-1:0]  sof_q, sof_d;
  logic [DP_LAT-1:0]  eof_q, eof_d;
`ifdef CO_PHASE_CONT_EN
  logic               cleared_q, cleared_d;
`endif

  logic acc_s;
  logic first_s;
  logic last_s;

  // Next-state and next-output computation for the whole sequencer
  always_comb begin
    acc_s   = (state_q == S_RUN) && in_valid;
    first_s = acc_s && (cnt_q == '0);
    last_s  = acc_s && (cnt_q == (len_q - LEN_W'(1)));

    state_d     = state_q;
    shadow_d    = cfg_load ? cfg_fcw : shadow_q;
    nco_fcw_d   = nco_fcw_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    nco_load_d  = 1'b0;
    nco_clr_d   = 1'b0;
    done_d      = 1'b0;
`ifdef CO_PHASE_CONT_EN
    cleared_d   = cleared_q;
`endif
    err_drop_d  = err_drop_q | (in_valid && (state_q != S_RUN));
    err_start_d = err_start_q |
                  (frame_start && ((state_q != S_IDLE) || (frame_len == '0)));

    case (state_q)
      S_IDLE: begin
        if (frame_start && (frame_len != '0)) begin
          len_d   = frame_len;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // A cfg_load landing in this very cycle wins over the stored shadow
        nco_fcw_d  = cfg_load ? cfg_fcw : shadow_q;
        nco_load_d = 1'b1;
`ifdef CO_PHASE_CONT_EN
        nco_clr_d  = ~cleared_q;
        cleared_d  = 1'b1;
`else
        nco_clr_d  = 1'b1;
`endif
        cnt_d      = '0;
        tmr_d      = WARM_INIT;
        state_d    = S_WARM;
      end
      S_WARM: begin
        if (tmr_q == '0) begin
          state_d = S_RUN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RUN: begin
        if (acc_s) begin
          cnt_d = cnt_q + LEN_W'(1);
        end
        if (last_s) begin
          tmr_d   = DRAIN_INIT;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tmr_q == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    vld_d  = {vld_q[DP_LAT-2:0], acc_s};
    sof_d  = {sof_q[DP_LAT-2:0], first_s};
    eof_d  = {eof_q[DP_LAT-2:0], last_s};
  end

  // State, shadow, counters and delay lines; everything clears on rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      nco_fcw_q   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      nco_load_q  <= 1'b0;
      nco_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_drop_q  <= 1'b0;
      err_start_q <= 1'b0;
      vld_q       <= '0;
      sof_q       <= '0;
      eof_q       <= '0;
`ifdef CO_PHASE_CONT_EN
      cleared_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      nco_fcw_q   <= nco_fcw_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      nco_load_q  <= nco_load_d;
      nco_clr_q   <= nco_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_drop_q  <= err_drop_d;
      err_start_q <= err_start_d;
      vld_q       <= vld_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
`ifdef CO_PHASE_CONT_EN
      cleared_q   <= cleared_d;
`endif
    end
  end

  // rot_en taps the delay line one stage before the output so the product
  // register is enabled in the cycle the sample reaches it
  assign nco_fcw    = nco_fcw_q;
  assign nco_load   = nco_load_q;
  assign nco_clr    = nco_clr_q;
  assign rot_en     = vld_q[DP_LAT-2];
  assign out_valid  = vld_q[DP_LAT-1];
  assign out_sof    = sof_q[DP_LAT-1];
  assign out_eof    = eof_q[DP_LAT-1];
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err_drop   = err_drop_q;
  assign err_start  = err_start_q;

endmodule
